pattern_detector_multi: RTL

Parametrised serial bit-pattern detector: counts occurrences of a runtime-programmable PATTERN_W-bit pattern in a strobed single-bit stream, in overlapping, non-overlapping or frame-aligned mode. Sits downstream of the Block-RAM bit reader, consuming one bit per enable strobe (e.g. the one-second tick), and drives the count display path plus a per-match pulse.

---
 rtl/seq_det_pkg.sv | 16 +
 rtl/seq_det_counter.sv | 45 ++++
 rtl/pattern_detector_multi.sv | 96 +++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - mode encodings and parameter limits for pattern_detector_multi
package seq_det_pkg;

    typedef enum logic [1:0] {
        MODE_OVERLAP    = 2'd0,
        MODE_NONOVERLAP = 2'd1,
        MODE_FRAMED     = 2'd2,
        MODE_RESERVED   = 2'd3
    } mode_e;

    localparam int PATTERN_W_MIN = 2;
    localparam int PATTERN_W_MAX = 16;
    localparam int COUNT_W_MIN   = 2;
    localparam int COUNT_W_MAX   = 32;

endpackage

// File: rtl/seq_det_counter.sv
// rtl/seq_det_counter.sv - occurrence counter with sticky overflow
// SEQ_DET_SATURATE_EN: hold at all-ones instead of wrapping to zero.
module seq_det_counter #(
    parameter int COUNT_W = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic               i_inc,
    output logic [COUNT_W-1:0] o_count,
    output logic               o_overflow
);

    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    logic [COUNT_W-1:0] r_count;
    logic               r_overflow;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (i_clear) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (i_inc) begin
`ifdef SEQ_DET_SATURATE_EN
            if (r_count == COUNT_MAX) begin
                r_overflow <= 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
            end
`else
            r_count <= r_count + 1'b1;
            if (r_count == COUNT_MAX) begin
                r_overflow <= 1'b1;
            end
`endif
        end
    end

    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/pattern_detector_multi.sv
// rtl/pattern_detector_multi.sv - serial pattern detector, overlap/non-overlap/framed modes
// SEQ_DET_SATURATE_EN selects a saturating counter (see seq_det_counter).
module pattern_detector_multi
    import seq_det_pkg::*;
#(
    parameter int PATTERN_W = 4,
    parameter int COUNT_W   = 8
) (
    input  logic                 clock_100Mhz,
    input  logic                 reset,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    input  logic [PATTERN_W-1:0] pattern,
    input  logic [1:0]           mode,
    input  logic                 clear,
    output logic [COUNT_W-1:0]   pattern_count,
    output logic                 match,
    output logic                 overflow
);

    localparam int FILL_W = $clog2(PATTERN_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PATTERN_W - 1);

    generate
        if (PATTERN_W < PATTERN_W_MIN || PATTERN_W > PATTERN_W_MAX ||
            COUNT_W < COUNT_W_MIN || COUNT_W > COUNT_W_MAX) begin : g_bad_params
            $error("pattern_detector_multi: PATTERN_W or COUNT_W out of range");
        end
    endgenerate

    logic [PATTERN_W-1:0] r_win;
    logic [FILL_W-1:0]    r_fill;
    logic [1:0]           r_mode_q;
    logic                 r_match;

    logic [PATTERN_W-1:0] w_next_win;
    logic [FILL_W-1:0]    w_fill_inc;
    mode_e                w_mode;
    logic                 w_mode_chg;
    logic                 w_hit;
    logic                 w_match;

    assign w_next_win = {r_win[PATTERN_W-2:0], bit_in};
    assign w_fill_inc = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + 1'b1;
    assign w_mode     = mode_e'(mode);
    assign w_mode_chg = (mode != r_mode_q);

    // A hit needs a full window after this bit; framed mode only looks at frame ends.
    always_comb begin
        w_match = 1'b0;
        w_hit   = bit_valid && !w_mode_chg && (w_next_win == pattern);
        case (w_mode)
            MODE_FRAMED: w_match = w_hit && (r_fill == FILL_LAST);
            default:     w_match = w_hit && (r_fill >= FILL_LAST);
        endcase
    end

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            r_win    <= '0;
            r_fill   <= '0;
            r_mode_q <= MODE_OVERLAP;
            r_match  <= 1'b0;
        end else begin
            r_mode_q <= mode;
            r_match  <= w_match;
            if (bit_valid) begin
                r_win <= w_next_win;
            end
            if (w_mode_chg) begin
                r_fill <= bit_valid ? FILL_W'(1) : '0;
            end else if (bit_valid) begin
                case (w_mode)
                    MODE_NONOVERLAP: r_fill <= w_match ? '0 : w_fill_inc;
                    MODE_FRAMED:     r_fill <= (r_fill == FILL_LAST) ? '0 : w_fill_inc;
                    default:         r_fill <= w_fill_inc;
                endcase
            end
        end
    end

    seq_det_counter #(
        .COUNT_W (COUNT_W)
    ) u_counter (
        .i_clk      (clock_100Mhz),
        .i_reset    (reset),
        .i_clear    (clear),
        .i_inc      (w_match),
        .o_count    (pattern_count),
        .o_overflow (overflow)
    );

    assign match = r_match;

endmodule
